// File: rtl/fnd_pkg.sv
// Shared types and helpers for the 4-digit FND scan path.
// The nibble extractor is also used by the downstream decoders.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 2;
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

  function automatic logic [NIBBLE_W-1:0] get_nibble(input logic [VALUE_W-1:0] word,
                                                     input logic [DIGIT_W-1:0]  idx);
    return word[{idx, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Free-running slot counter 0..DIV-1 with slot_end on the last cycle of a slot
// and blank_end on the last blanking cycle. Synchronous clear holds it at 0.
module fnd_slot_timer #(
  parameter int unsigned DIV          = 10,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  output logic o_slot_end,
  output logic o_blank_end
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap on an explicit compare so non-power-of-two DIV never runs past DIV-1.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clear || (cnt_q == CNT_LAST)) cnt_d = '0;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign o_slot_end  = (cnt_q == CNT_LAST);
  assign o_blank_end = (cnt_q == BLANK_LAST);

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scan driver: frame snapshot, per-slot blanking
// gap, leading-zero suppression and fully registered decoder-facing outputs.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1_000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic [VALUE_W-1:0]    i_value,
  input  logic [NUM_DIGITS-1:0] i_dp,
  input  logic                  i_lz_blank,
  output logic [DIGIT_W-1:0]    o_digitSelect,
  output logic [NIBBLE_W-1:0]   o_value,
  output logic                  o_dp,
  output logic                  o_en,
  output logic                  o_frame
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;

  state_e                state_q, state_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic [VALUE_W-1:0]    snap_value_q, snap_value_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic                  snap_lz_q, snap_lz_d;
  logic [DIGIT_W-1:0]    sel_q, sel_d;
  logic [NIBBLE_W-1:0]   value_q, value_d;
  logic                  dp_q, dp_d;
  logic                  en_q, en_d;
  logic                  frame_q, frame_d;

  logic slot_end, blank_end, timer_clear, lit_now;

  // A digit is dark only when it and every more-significant nibble are zero.
  function automatic logic digit_lit(input logic [VALUE_W-1:0]    v,
                                     input logic [NUM_DIGITS-1:0] dp,
                                     input logic                  lz,
                                     input logic [DIGIT_W-1:0]    k);
    logic [VALUE_W-1:0] upper;
    upper = v >> {k, 2'b00};
    return (k == '0) || !lz || dp[k] || (upper != '0);
  endfunction

  assign timer_clear = !i_en || (state_q == IDLE);
  assign lit_now     = digit_lit(snap_value_q, snap_dp_q, snap_lz_q, digit_q);

  fnd_slot_timer #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (timer_clear),
    .o_slot_end  (slot_end),
    .o_blank_end (blank_end)
  );

  always_comb begin
    // NOTE: every _d takes a default first, so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d      = state_q;
    digit_d      = digit_q;
    snap_value_d = snap_value_q;
    snap_dp_d    = snap_dp_q;
    snap_lz_d    = snap_lz_q;
    en_d         = 1'b0;
    frame_d      = 1'b0;

    if (!i_en) begin
      state_d = IDLE;
      digit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          snap_value_d = i_value;
          snap_dp_d    = i_dp;
          snap_lz_d    = i_lz_blank;
          frame_d      = 1'b1;
          digit_d      = '0;
          state_d      = BLANK;
        end
        BLANK: begin
          if (blank_end) begin
            state_d = SHOW;
            en_d    = lit_now;
          end
        end
        SHOW: begin
          if (slot_end) begin
            state_d = BLANK;
            digit_d = digit_q + DIGIT_W'(1);
            if (digit_q == DIGIT_W'(NUM_DIGITS - 1)) begin
              snap_value_d = i_value;
              snap_dp_d    = i_dp;
              snap_lz_d    = i_lz_blank;
              frame_d      = 1'b1;
            end
          end else begin
            en_d = lit_now;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // digit_d and the snapshot only move on slot boundaries, so these do too.
    if (state_d == IDLE) begin
      sel_d   = '0;
      value_d = '0;
      dp_d    = 1'b0;
    end else begin
      sel_d   = digit_d;
      value_d = get_nibble(snap_value_d, digit_d);
      dp_d    = snap_dp_d[digit_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      digit_q      <= '0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_lz_q    <= 1'b0;
      sel_q        <= '0;
      value_q      <= '0;
      dp_q         <= 1'b0;
      en_q         <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_lz_q    <= snap_lz_d;
      sel_q        <= sel_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      en_q         <= en_d;
      frame_q      <= frame_d;
    end
  end

  assign o_digitSelect = sel_q;
  assign o_value       = value_q;
  assign o_dp          = dp_q;
  assign o_en          = en_q;
  assign o_frame       = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (DIV=10, BLANK_CYCLES=2) against a
// time-indexed reference model: cycle t of a run maps to slot t/10, position t%10.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz;
  logic [1:0]  sel;
  logic [3:0]  oval;
  logic        odp, oen, oframe;

  int errors = 0;
  int checks = 0;

  // Reference model state: active run, cycles since run start, frame snapshot.
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] m_v = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  lit_mask;
  } vec_t;

  vec_t vecs[9];
  int   basic_exp[4] = '{4, 3, 2, 1};

  fnd_scan_controller #(
    .CLK_HZ       (100),
    .SCAN_HZ      (10),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_en          (en),
    .i_value       (value),
    .i_dp          (dp),
    .i_lz_blank    (lz),
    .o_digitSelect (sel),
    .o_value       (oval),
    .o_dp          (odp),
    .o_en          (oen),
    .o_frame       (oframe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int k);
    return 4'((int'(v) / (1 << (4 * k))) % 16);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},   32'(sel),    32'd0);
    check({tag, "_value"}, 32'(oval),   32'd0);
    check({tag, "_dp"},    32'(odp),    32'd0);
    check({tag, "_en"},    32'(oen),    32'd0);
    check({tag, "_frame"}, 32'(oframe), 32'd0);
  endtask

  task automatic compare_model();
    int   slot, pos, msd;
    logic lit;
    if (!m_active) begin
      check_all_zero("model_off");
    end else begin
      slot = (m_t / 10) % 4;
      pos  = m_t % 10;
      msd  = 0;
      for (int k = 0; k < 4; k++) if (nib(m_v, k) != 4'd0) msd = k;
      lit = !m_lz || (slot <= msd) || m_dp[slot];
      check("model_sel",   32'(sel),    32'(slot));
      check("model_value", 32'(oval),   32'(nib(m_v, slot)));
      check("model_dp",    32'(odp),    32'(m_dp[slot]));
      check("model_en",    32'(oen),    32'((pos >= 2) && lit));
      check("model_frame", 32'(oframe), 32'(m_t % 40 == 0));
    end
  endtask

  task automatic take_snapshot();
    m_v  = value;
    m_dp = dp;
    m_lz = lz;
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst_n || !en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
      take_snapshot();
    end else begin
      m_t++;
      if (m_t % 40 == 0) take_snapshot();
    end
    #1;
    compare_model();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    value = '0;
    dp    = '0;
    lz    = 1'b0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111};
    vecs[1] = '{16'h0040, 4'b0000, 1'b1, 4'b0011};
    vecs[2] = '{16'h0040, 4'b1000, 1'b1, 4'b1011};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, 4'b0001};
    vecs[4] = '{16'h0000, 4'b0100, 1'b1, 4'b0101};
    vecs[5] = '{16'h0300, 4'b0000, 1'b1, 4'b0111};
    vecs[6] = '{16'h1000, 4'b0000, 1'b1, 4'b1111};
    vecs[7] = '{16'h0005, 4'b0000, 1'b1, 4'b0001};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, 4'b1111};

    // Reset state, then release with scanning disabled.
    #2;
    check_all_zero("reset");
    #10 rst_n = 1'b1;
    repeat (3) step();
    check("idle_en", 32'(oen), 32'd0);

    // Basic scan of 1234 over two frames.
    value = 16'h1234;
    en    = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (m_t % 40 == 0) check("basic_frame", 32'(oframe), 32'd1);
      if (m_t % 10 == 1) check("basic_blank", 32'(oen), 32'd0);
      if (m_t % 10 == 2) begin
        check("basic_value", 32'(oval), 32'(basic_exp[(m_t / 10) % 4]));
        check("basic_lit",   32'(oen),  32'd1);
      end
    end

    // Mid-frame input change must wait for the next frame.
    for (int i = 0; i < 70; i++) begin
      step();
      if (m_t == 95)  value = 16'hABCD;
      if (m_t == 115) check("snap_old_d3", 32'(oval), 32'h1);
      if (m_t == 125) check("snap_new_d0", 32'(oval), 32'hD);
      if (m_t == 135) check("snap_new_d1", 32'(oval), 32'hC);
      if (m_t == 145) check("snap_new_d2", 32'(oval), 32'hB);
    end

    // Leading-zero and decimal-point table, one full frame each.
    for (int v = 0; v < 9; v++) begin
      en = 1'b0;
      step();
      value = vecs[v].value;
      dp    = vecs[v].dp;
      lz    = vecs[v].lz;
      en    = 1'b1;
      for (int i = 0; i < 40; i++) begin
        step();
        if (m_t % 10 >= 2)
          check($sformatf("lz_mask_v%0d_s%0d", v, (m_t / 10) % 4), 32'(oen),
                32'(vecs[v].lit_mask[(m_t / 10) % 4]));
      end
    end

    // Disable in SHOW on digit 2, then re-enable.
    en    = 1'b0;
    step();
    value = 16'h1234;
    dp    = 4'b0000;
    lz    = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 26; i++) step();
    check("dis_pre_sel", 32'(sel), 32'd2);
    check("dis_pre_en",  32'(oen), 32'd1);
    en = 1'b0;
    step();
    check("dis_en",  32'(oen), 32'd0);
    check("dis_sel", 32'(sel), 32'd0);
    step();
    en = 1'b1;
    step();
    check("reen_frame", 32'(oframe), 32'd1);
    check("reen_blank0", 32'(oen), 32'd0);
    step();
    check("reen_blank1", 32'(oen), 32'd0);
    step();
    check("reen_lit", 32'(oen), 32'd1);
    check("reen_sel", 32'(sel), 32'd0);

    // Asynchronous reset pulse mid-slot, off the clock edge.
    for (int i = 0; i < 31; i++) step();
    #3 rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    check_all_zero("async_rst");
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    check("post_rst_frame", 32'(oframe), 32'd1);
    check("post_rst_blank0", 32'(oen), 32'd0);
    step();
    check("post_rst_blank1", 32'(oen), 32'd0);
    step();
    check("post_rst_lit", 32'(oen), 32'd1);
    check("post_rst_sel", 32'(sel), 32'd0);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 30; r++) begin
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      lz    = 1'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(1, 60)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
